park_channel_scheduler: RTL and testbench

//  Shares one Park-transform datapath (theta/alpha/beta in, d/q out, fixed pipeline latency) among
//  N_CHANNELS requesters, e.g. several converter legs or motors in the transform acceleration unit.

---
 rtl/park_channel_scheduler.sv | 158 +++++++++++++++
 tb/tb_park_channel_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_channel_scheduler.sv
// park_channel_scheduler
//   Shares one fixed-latency Park-transform datapath among N_CHANNELS requesters.
//   A round-robin arbiter grants at most one request per cycle. A tag pipeline
//   carries {valid, channel} beside each sample so that every d/q result comes
//   back labelled with its channel. flush blocks new grants and lets the
//   in-flight samples drain.
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   req_valid / req_ready        per-channel handshake, req_ready is a one-hot grant
//   req_theta/alpha/beta         packed per-channel samples (16/18/18 bits each)
//   flush                        level; blocks grants, drains the datapath
//   park_valid/theta/alpha/beta  registered issue to the shared datapath
//   park_d, park_q               datapath results, PARK_LATENCY after park_valid
//   out_valid/channel/d/q        registered, channel-labelled results
//   busy                         samples in flight
//   state                        0 IDLE, 1 ACTIVE, 2 FLUSH
//
// state  | meaning
// IDLE   | nothing in flight, waiting for the first handshake
// ACTIVE | issuing and/or draining samples
// FLUSH  | grants blocked until flush drops and the datapath is empty
module park_channel_scheduler #(
   parameter int N_CHANNELS   = 4,
   parameter int PARK_LATENCY = 3,
   parameter int CH_W         = $clog2(N_CHANNELS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_CHANNELS-1:0]    req_valid,
   output logic [N_CHANNELS-1:0]    req_ready,
   input  logic [16*N_CHANNELS-1:0] req_theta,
   input  logic [18*N_CHANNELS-1:0] req_alpha,
   input  logic [18*N_CHANNELS-1:0] req_beta,
   input  logic                     flush,
   output logic                     park_valid,
   output logic [15:0]              park_theta,
   output logic [17:0]              park_alpha,
   output logic [17:0]              park_beta,
   input  logic [17:0]              park_d,
   input  logic [17:0]              park_q,
   output logic                     out_valid,
   output logic [CH_W-1:0]          out_channel,
   output logic [17:0]              out_d,
   output logic [17:0]              out_q,
   output logic                     busy,
   output logic [1:0]               state
);

   localparam int IF_W = $clog2(PARK_LATENCY + 3);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_FLUSH  = 2'd2;

   logic [CH_W-1:0] rr_ptr;
   logic [CH_W-1:0] grant;
   logic            grant_found;
   logic            block;
   logic            handshake;
   int              idx;
   logic [CH_W-1:0] park_ch;
   logic            tag_v  [PARK_LATENCY];
   logic [CH_W-1:0] tag_ch [PARK_LATENCY];
   logic [IF_W-1:0] in_flight;

   // Scan rr_ptr, rr_ptr+1, ... modulo N; first requester wins.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      idx         = 0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant       = CH_W'(idx);
         end
      end
   end

   // The flush input itself blocks grants too, so a request arriving in the
   // same cycle that flush rises keeps waiting.
   assign block     = flush || (state == ST_FLUSH);
   assign handshake = grant_found && !block;
   assign busy      = (in_flight != '0);

   always_comb begin
      req_ready = '0;
      if (handshake) req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr      <= '0;
         park_valid  <= 1'b0;
         park_theta  <= '0;
         park_alpha  <= '0;
         park_beta   <= '0;
         park_ch     <= '0;
         out_valid   <= 1'b0;
         out_channel <= '0;
         out_d       <= '0;
         out_q       <= '0;
         in_flight   <= '0;
         state       <= ST_IDLE;
         for (int i = 0; i < PARK_LATENCY; i++) begin
            tag_v[i]  <= 1'b0;
            tag_ch[i] <= '0;
         end
      end else begin
         park_valid <= handshake;
         if (handshake) begin
            park_theta <= req_theta[16*grant +: 16];
            park_alpha <= req_alpha[18*grant +: 18];
            park_beta  <= req_beta[18*grant +: 18];
            park_ch    <= grant;
            rr_ptr     <= (grant == CH_W'(N_CHANNELS - 1)) ? '0 : grant + 1'b1;
         end

         // Stage 0 is loaded from the issue register, so the last stage lines
         // up with park_d/park_q PARK_LATENCY cycles after park_valid.
         tag_v[0]  <= park_valid;
         tag_ch[0] <= park_ch;
         for (int i = 1; i < PARK_LATENCY; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_ch[i] <= tag_ch[i-1];
         end

         out_valid   <= tag_v[PARK_LATENCY-1];
         out_channel <= tag_ch[PARK_LATENCY-1];
         out_d       <= park_d;
         out_q       <= park_q;

         case ({handshake, out_valid})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase

         case (state)
            ST_IDLE: begin
               if (flush)          state <= ST_FLUSH;
               else if (handshake) state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (flush)                                state <= ST_FLUSH;
               else if (in_flight == '0 && !handshake) state <= ST_IDLE;
            end
            ST_FLUSH: begin
               if (!flush && in_flight == '0) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_park_channel_scheduler.sv
module tb_park_channel_scheduler;

   localparam int N = 4;
   localparam int L = 3;
   localparam int CW = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [16*N-1:0]   req_theta;
   logic [18*N-1:0]   req_alpha;
   logic [18*N-1:0]   req_beta;
   logic              flush;
   logic              park_valid;
   logic [15:0]       park_theta;
   logic [17:0]       park_alpha;
   logic [17:0]       park_beta;
   logic [17:0]       park_d;
   logic [17:0]       park_q;
   logic              out_valid;
   logic [CW-1:0]     out_channel;
   logic [17:0]       out_d;
   logic [17:0]       out_q;
   logic              busy;
   logic [1:0]        state;

   park_channel_scheduler #(.N_CHANNELS(N), .PARK_LATENCY(L), .CH_W(CW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_theta(req_theta), .req_alpha(req_alpha), .req_beta(req_beta),
      .flush(flush),
      .park_valid(park_valid), .park_theta(park_theta),
      .park_alpha(park_alpha), .park_beta(park_beta),
      .park_d(park_d), .park_q(park_q),
      .out_valid(out_valid), .out_channel(out_channel),
      .out_d(out_d), .out_q(out_q),
      .busy(busy), .state(state)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Datapath stand-in: fixed latency L, results are a simple function of the
   // sample so that mislabelled or misaligned results are visible.
   logic [15:0] dp_th [L+1];
   logic [17:0] dp_al [L+1];
   logic [17:0] dp_be [L+1];

   function automatic logic [17:0] fd(logic [15:0] th, logic [17:0] al);
      return al ^ {2'b00, th};
   endfunction
   function automatic logic [17:0] fq(logic [15:0] th, logic [17:0] be);
      return be + {2'b00, th};
   endfunction

   always @(posedge clock) begin
      #1;
      for (int i = L; i > 0; i--) begin
         dp_th[i] = dp_th[i-1];
         dp_al[i] = dp_al[i-1];
         dp_be[i] = dp_be[i-1];
      end
      dp_th[0] = park_theta;
      dp_al[0] = park_alpha;
      dp_be[0] = park_beta;
      park_d = fd(dp_th[L], dp_al[L]);
      park_q = fq(dp_th[L], dp_be[L]);
   end

   // Scoreboard
   typedef struct { logic [15:0] th; logic [17:0] al; logic [17:0] be; int due; } iss_t;
   typedef struct { int ch; logic [17:0] d; logic [17:0] q; int due; } res_t;
   iss_t iq[$];
   res_t rq[$];

   always @(negedge clock) begin
      iss_t it;
      res_t rt;
      if (iq.size() != 0 && iq[0].due <= cyc) begin
         it = iq.pop_front();
         chk("park_valid", park_valid, 1);
         if (park_valid === 1'b1) begin
            chk("park_theta", park_theta, it.th);
            chk("park_alpha", park_alpha, it.al);
            chk("park_beta", park_beta, it.be);
         end
      end else begin
         chk("park_valid_idle", park_valid, 0);
      end
      if (rq.size() != 0 && rq[0].due <= cyc) begin
         rt = rq.pop_front();
         chk("out_valid", out_valid, 1);
         if (out_valid === 1'b1) begin
            chk("out_channel", out_channel, rt.ch);
            chk("out_d", out_d, rt.d);
            chk("out_q", out_q, rt.q);
         end
      end else begin
         chk("out_valid_idle", out_valid, 0);
      end
   end

   // Reference model state
   bit          pend [N];
   logic [15:0] dth  [N];
   logic [17:0] dal  [N];
   logic [17:0] dbe  [N];
   bit          auto_mask [N];
   int          prob = 0;
   bit          reset_i = 0;
   bit          flush_i = 0;
   int          rr = 0;
   int          mst = 0;
   int          last_hs = -100;
   logic [15:0] last_th = '0;
   int          grants [$];

   task automatic step();
      int g;
      bit hs;
      bit bz;
      logic [N-1:0] exp_rdy;
      for (int k = 0; k < N; k++) begin
         if (auto_mask[k] && !pend[k] && $urandom_range(99) < prob) begin
            pend[k] = 1;
            dth[k]  = 16'($urandom);
            dal[k]  = 18'($urandom);
            dbe[k]  = 18'($urandom);
         end
      end
      reset = reset_i;
      flush = flush_i;
      for (int k = 0; k < N; k++) begin
         req_valid[k]           = reset_i ? 1'b0 : pend[k];
         req_theta[16*k +: 16]  = dth[k];
         req_alpha[18*k +: 18]  = dal[k];
         req_beta[18*k +: 18]   = dbe[k];
      end
      @(negedge clock);
      if (!reset_i) begin
         g = -1;
         if (!flush_i && mst != 2) begin
            for (int i = 0; i < N; i++) begin
               int k;
               k = (rr + i) % N;
               if (g < 0 && pend[k]) g = k;
            end
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         bz = (last_hs + L + 2 >= cyc);
         chk("req_ready", req_ready, exp_rdy);
         chk("busy", busy, bz);
         chk("state", state, mst);
         hs = (g >= 0);
         if (hs) begin
            iq.push_back('{dth[g], dal[g], dbe[g], cyc + 1});
            rq.push_back('{g, fd(dth[g], dal[g]), fq(dth[g], dbe[g]), cyc + L + 2});
            grants.push_back(g);
            rr      = (g + 1) % N;
            pend[g] = 0;
            last_hs = cyc;
            last_th = dth[g];
         end
         if (flush_i)       mst = 2;
         else if (mst == 0) mst = hs ? 1 : 0;
         else if (mst == 1) mst = (!bz && !hs) ? 0 : 1;
         else               mst = bz ? 2 : 0;
      end
      @(posedge clock);
      #1;
      if (reset_i) begin
         iq.delete();
         rq.delete();
         rr      = 0;
         mst     = 0;
         last_hs = -100;
         last_th = '0;
      end
   endtask

   task automatic set_auto(bit a0, bit a1, bit a2, bit a3, int p);
      auto_mask[0] = a0; auto_mask[1] = a1; auto_mask[2] = a2; auto_mask[3] = a3;
      prob = p;
   endtask

   task automatic do_reset();
      reset_i = 1;
      step();
      reset_i = 0;
   endtask

   initial begin
      for (int i = 0; i <= L; i++) begin
         dp_th[i] = '0; dp_al[i] = '0; dp_be[i] = '0;
      end
      for (int k = 0; k < N; k++) begin
         pend[k] = 0; dth[k] = '0; dal[k] = '0; dbe[k] = '0; auto_mask[k] = 0;
      end
      reset = 1; flush = 0; req_valid = '0;
      req_theta = '0; req_alpha = '0; req_beta = '0;
      park_d = '0; park_q = '0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();

      chk("rst_park_valid", park_valid, 0);
      chk("rst_park_theta", park_theta, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_d", out_d, 0);
      chk("rst_out_channel", out_channel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", state, 0);

      // Single channel on ch2
      set_auto(0, 0, 0, 0, 0);
      pend[2] = 1; dth[2] = 16'h4000; dal[2] = 18'd1000; dbe[2] = 18'(-500);
      repeat (10) step();

      // All channels continuously from reset: grants 0,1,2,3,...
      do_reset();
      grants.delete();
      set_auto(1, 1, 1, 1, 100);
      repeat (15) step();
      for (int i = 0; i < 15; i++) chk("rr_order", grants[i], i % N);

      // Wrap: rr_ptr is now 3, only ch1 and ch3 request
      set_auto(0, 1, 0, 1, 100);
      for (int k = 0; k < N; k++) pend[k] = 0;
      grants.delete();
      repeat (3) step();
      chk("wrap_g0", grants[0], 3);
      chk("wrap_g1", grants[1], 1);
      chk("wrap_g2", grants[2], 3);
      set_auto(0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) pend[k] = 0;
      repeat (8) step();

      // Flush with 3 in flight and ch0 waiting
      set_auto(0, 1, 1, 1, 100);
      repeat (3) step();
      set_auto(0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) pend[k] = 0;
      pend[0] = 1; dth[0] = 16'h1234; dal[0] = 18'h2abcd; dbe[0] = 18'h01111;
      flush_i = 1;
      repeat (8) step();
      chk("flush_ch0_waiting", pend[0], 1);
      flush_i = 0;
      repeat (6) step();

      // Reset with 2 in flight
      set_auto(1, 1, 1, 1, 100);
      repeat (2) step();
      set_auto(0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) pend[k] = 0;
      do_reset();
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_park_valid", park_valid, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_state", state, 0);
      chk("rst2_out_q", out_q, 0);
      repeat (8) step();
      grants.delete();
      set_auto(1, 1, 1, 1, 100);
      step();
      chk("rst2_first_grant", grants[0], 0);
      set_auto(0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) pend[k] = 0;

      // Long idle: issue outputs hold
      repeat (100) step();
      chk("idle_theta_hold", park_theta, last_th);
      chk("idle_state", state, 0);

      // Randomized traffic with occasional flush and reset
      for (int n = 0; n < 900; n++) begin
         if (n % 50 == 0)
            set_auto(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(20, 90));
         if (!flush_i && $urandom_range(99) < 2) flush_i = 1;
         else if (flush_i && $urandom_range(99) < 25) flush_i = 0;
         if ($urandom_range(399) == 0) do_reset();
         else step();
      end
      flush_i = 0;
      set_auto(0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) pend[k] = 0;
      repeat (15) step();
      chk("drain_issue_q", iq.size(), 0);
      chk("drain_result_q", rq.size(), 0);
      chk("drain_state", state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
